// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder: one bit per clock, MSB first, valid/ready on both sides.
// Optional step checker enabled by defining GRAY2BIN_DELTA_CHECK_EN (adds the delta_err port).
module gray_to_bin_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
`ifdef GRAY2BIN_DELTA_CHECK_EN
    output logic             delta_err,
`endif
    output logic             busy
);

    localparam int unsigned     IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StConv = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             bit_q, bit_d;
    logic             cur_bit;
    logic             accept;
    logic             finish;

    assign accept = (state_q == StIdle) && in_valid;
    assign finish = (state_q == StConv) && (idx_q == '0);

    // bit_q carries the already-resolved higher binary bit; it is 0 ahead of the MSB.
    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cur_bit = bit_q ^ gray_q[idx_q];
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    gray_d  = gray_in;
                    idx_d   = IdxMax;
                    bit_d   = 1'b0;
                    state_d = StConv;
                end
            end
            StConv: begin
                acc_d[idx_q] = cur_bit;
                bit_d        = cur_bit;
                if (idx_q == '0) begin
                    bin_d   = acc_d;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gray_q  <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            idx_q   <= IdxMax;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
        end
    end

`ifdef GRAY2BIN_DELTA_CHECK_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic             pend_q, pend_d;
    logic             derr_q, derr_d;
    logic [WIDTH-1:0] diff;

    // More than one differing bit <=> clearing the lowest set bit leaves something behind.
    assign diff = gray_in ^ prev_q;

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        pend_d     = pend_q;
        derr_d     = derr_q;
        if (accept) begin
            prev_d     = gray_in;
            prev_vld_d = 1'b1;
            pend_d     = prev_vld_q && ((diff & (diff - WIDTH'(1))) != '0);
        end
        if (finish) begin
            derr_d = pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            pend_q     <= pend_d;
            derr_q     <= derr_d;
        end
    end

    assign delta_err = derr_q;
`else
    logic unused_flags;
    assign unused_flags = accept ^ finish;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StConv);
    assign bin_out   = bin_q;

endmodule

// File: tb/tb_gray_to_bin_serial.sv
// Self-checking bench for gray_to_bin_serial (WIDTH=4): vector table, corner sequences, random.
module tb_gray_to_bin_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bin_out;
    logic         busy;
`ifdef GRAY2BIN_DELTA_CHECK_EN
    logic         delta_err;
    logic         m_prev_vld;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_to_bin_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
`ifdef GRAY2BIN_DELTA_CHECK_EN
        .delta_err (delta_err),
`endif
        .busy      (busy)
    );

    typedef struct packed {
        logic [W-1:0] gray;
        logic [W-1:0] bin;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: binary = XOR of the Gray word with every right shift of itself.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        logic [W-1:0] t = g;
        for (int i = 0; i < W; i++) begin
            b ^= t;
            t = t >> 1;
        end
        return b;
    endfunction

    // Called at a negedge in IDLE; returns at the first negedge where out_valid is seen.
    task automatic run_code(input logic [W-1:0] g, output int lat, output int bcnt);
        int k;
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        gray_in  = g;
        @(negedge clk);
        in_valid = 1'b0;
        gray_in  = W'($urandom);
        k        = 1;
        bcnt     = 0;
        while (!out_valid && k < 20) begin
            if (busy) bcnt++;
            if (in_ready) begin
                errors++;
                checks++;
                $display("FAIL in_ready_during_conv: got 1, expected 0");
            end
            @(negedge clk);
            k++;
        end
        lat = k - 1;
    endtask

    initial begin
        int lat, bcnt, d;
        logic [W-1:0] g, last_g, one, held;

        // Expected values written out by hand, not computed.
        vecs[0]  = '{4'b0000, 4'b0000};  vecs[1]  = '{4'b0001, 4'b0001};
        vecs[2]  = '{4'b0010, 4'b0011};  vecs[3]  = '{4'b0011, 4'b0010};
        vecs[4]  = '{4'b0100, 4'b0111};  vecs[5]  = '{4'b0101, 4'b0110};
        vecs[6]  = '{4'b0110, 4'b0100};  vecs[7]  = '{4'b0111, 4'b0101};
        vecs[8]  = '{4'b1000, 4'b1111};  vecs[9]  = '{4'b1001, 4'b1110};
        vecs[10] = '{4'b1010, 4'b1100};  vecs[11] = '{4'b1011, 4'b1101};
        vecs[12] = '{4'b1100, 4'b1000};  vecs[13] = '{4'b1101, 4'b1001};
        vecs[14] = '{4'b1110, 4'b1011};  vecs[15] = '{4'b1111, 4'b1010};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        gray_in   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bin_out", bin_out, 0);
`ifdef GRAY2BIN_DELTA_CHECK_EN
        check("rst_delta_err", delta_err, 0);
`endif

        // Basic decode with the consumer always ready.
        out_ready = 1'b1;
        run_code(4'b0110, lat, bcnt);
        check("basic_latency", lat, 4);
        check("basic_busy_cycles", bcnt, 4);
        check("basic_bin", bin_out, 4'b0100);
        @(negedge clk);
        check("basic_back_idle", in_ready, 1);
        check("basic_out_valid_low", out_valid, 0);
        check("basic_bin_held_idle", bin_out, 4'b0100);

        // Exhaustive table.
        for (int i = 0; i < 16; i++) begin
            run_code(vecs[i].gray, lat, bcnt);
            check($sformatf("table_bin_%0d", i), bin_out, vecs[i].bin);
            check($sformatf("table_lat_%0d", i), lat, 4);
            @(negedge clk);
        end

        // Backpressure: result held, a new in_valid is ignored while in DONE.
        out_ready = 1'b0;
        run_code(4'b1000, lat, bcnt);
        check("bp_bin", bin_out, 4'b1111);
        in_valid = 1'b1;
        gray_in  = 4'b0011;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_bin_stable", bin_out, 4'b1111);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_busy", busy, 0);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_bin_held", bin_out, 4'b1111);

        // Reset landing on the second CONV edge.
        in_valid = 1'b1;
        gray_in  = 4'b0110;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bin", bin_out, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        last_g = 4'b0000;

`ifdef GRAY2BIN_DELTA_CHECK_EN
        run_code(4'b0001, lat, bcnt);
        check("delta_first", delta_err, 0);
        @(negedge clk);
        run_code(4'b0010, lat, bcnt);
        check("delta_two_bits", delta_err, 1);
        @(negedge clk);
        run_code(4'b0011, lat, bcnt);
        check("delta_one_bit", delta_err, 0);
        @(negedge clk);
        last_g     = 4'b0011;
        m_prev_vld = 1'b1;
`endif

        // Random codes with random result stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                one = 4'b0001;
                g   = last_g ^ (one << $urandom_range(0, W - 1));
            end else begin
                g = W'($urandom);
            end
            out_ready = 1'b0;
            run_code(g, lat, bcnt);
            check("rand_lat", lat, 4);
            check("rand_bin", bin_out, g2b(g));
            held = bin_out;
`ifdef GRAY2BIN_DELTA_CHECK_EN
            check("rand_delta", delta_err, m_prev_vld && ($countones(g ^ last_g) > 1));
`endif
            d = $urandom_range(0, 2);
            for (int s = 0; s < d; s++) begin
                @(negedge clk);
                check("rand_stall_valid", out_valid, 1);
                check("rand_stall_bin", bin_out, held);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("rand_back_idle", in_ready, 1);
            last_g = g;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_to_bin_serial.md
GRAY_TO_BIN_SERIAL -- requirements
Module: gray_to_bin_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the code width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  gray_in holds a valid code.
REQ-005 SHALL have port in_ready  output  1  block can accept a code.
REQ-006 SHALL have port gray_in  input  WIDTH  Gray-coded input word.
REQ-007 SHALL have port out_valid  output  1  bin_out holds a finished result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port bin_out  output  WIDTH  decoded binary word.
REQ-010 SHALL have port busy  output  1  high while in the CONV state.
REQ-011 SHALL have port delta_err  output  1  step-violation flag; present only with GRAY2BIN_DELTA_CHECK_EN.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CONV and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; out_valid and busy SHALL be 0.
REQ-014 On an edge with in_valid=1 and in_ready=1, SHALL capture gray_in, load bit index WIDTH-1, and enter CONV.
REQ-015 In CONV, SHALL resolve one bit per edge, MSB first: bin[WIDTH-1]=gray[WIDTH-1]; bin[i]=bin[i+1] XOR gray[i].
REQ-016 SHALL leave CONV for DONE on the WIDTH-th edge after acceptance.
REQ-017 out_valid SHALL therefore first be high in the cycle following that WIDTH-th edge.
REQ-018 In DONE, out_valid SHALL be 1 and in_ready SHALL be 0.
REQ-019 In DONE, bin_out (and delta_err) SHALL hold stable until an edge with out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-020 in_ready SHALL be 0 in CONV and DONE; no new code is accepted before the result handshake completes.
REQ-021 With out_ready tied high, minimum spacing between accepted inputs SHALL be WIDTH+2 cycles.
REQ-022 bin_out SHALL retain the last completed result while in IDLE and CONV.
REQ-023 in_valid SHALL be ignored outside IDLE; gray_in changes after capture SHALL NOT affect the result.
REQ-024 bin_out SHALL be exactly WIDTH bits; no sign extension and no wrap hazard; all-ones Gray input SHALL decode normally.

Reset
REQ-025 When rst_n=0 at an edge, SHALL enter IDLE from any state, including mid-CONV and DONE; any partial result is discarded.
REQ-026 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, bin_out=0, delta_err=0, bit index=WIDTH-1.
REQ-027 With GRAY2BIN_DELTA_CHECK_EN, reset SHALL also clear the stored previous code and its history-valid flag.

Configuration
REQ-028 Macro GRAY2BIN_DELTA_CHECK_EN defined: SHALL store each accepted code and compute delta_err at acceptance.
REQ-029 delta_err SHALL be 1 when the new code and the previous accepted code differ in more than one bit position.
REQ-030 delta_err SHALL be 0 when the codes differ in zero or one bit, and for the first code after reset.
REQ-031 delta_err SHALL be presented with the same timing and hold rules as bin_out.
REQ-032 Macro GRAY2BIN_DELTA_CHECK_EN undefined: SHALL omit the delta_err port and the history logic; all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-033 SHALL test basic decode: accept gray_in=0110 with out_ready=1 -> out_valid rises 4 edges after acceptance, bin_out=0100, busy high for exactly 4 cycles.
REQ-034 SHALL test exhaustive decode: all 16 codes 0000..1111 -> bin_out equals the inverse Gray value (1000->1111, 1111->1010).
REQ-035 SHALL test backpressure: gray_in=1000 with out_ready=0 for 3 cycles -> bin_out=1111 and out_valid=1 held stable, in_ready=0 throughout, and a second in_valid is ignored.
REQ-036 SHALL test reset mid-operation: rst_n=0 on the 2nd CONV edge -> next cycle shows IDLE, in_ready=1, out_valid=0, bin_out=0000.
REQ-037 SHALL test delta check (macro on): codes 0001, 0010, 0011 -> delta_err=0, 1, 0 respectively.
REQ-038 SHALL test with the macro off: build compiles with no delta_err port and REQ-033 results are unchanged.
